// File: rtl/hbridge_sequencer.sv
// hbridge_sequencer: boot/precharge/run sequencing and latched fault
// protection in front of the full-bridge gate pins.
module hbridge_sequencer #(
  parameter int unsigned BOOT_CYCLES  = 1000,
  parameter int unsigned PRECH_CYCLES = 400,
  parameter int unsigned RAMP_CYCLES  = 10000,
  parameter logic [7:0]  PHI_START    = 8'd0,
  parameter logic [7:0]  VBAT_MAX     = 8'd200,
  parameter logic [7:0]  IBAT_MAX     = 8'd100,
  parameter int unsigned FLT_FILTER   = 8
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_enable,
  input  logic       i_fault_clear,
  input  logic [3:0] i_MOSFET,
  input  logic [7:0] i_phi_target,
  input  logic [7:0] i_Vbat,
  input  logic [7:0] i_Ibat,
  output logic [3:0] o_Q,
  output logic [7:0] o_phi,
  output logic       o_ctrl_rst_n,
  output logic [2:0] o_state,
  output logic [2:0] o_fault,
  output logic       o_running
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOOT  = 3'd1,
    S_PRECH = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam int FW = $clog2(FLT_FILTER + 1);
  localparam logic [15:0] BOOT_LAST  = 16'(BOOT_CYCLES - 1);
  localparam logic [15:0] PRECH_LAST = 16'(PRECH_CYCLES - 1);
  localparam logic [15:0] RAMP_LAST  = 16'(RAMP_CYCLES - 1);
  localparam logic [FW-1:0] FLT_MAX  = FW'(FLT_FILTER);

  state_e          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [15:0]     ramp_q, ramp_d;
  logic [FW-1:0]   ov_cnt_q, ov_cnt_d;
  logic [FW-1:0]   oc_cnt_q, oc_cnt_d;
  logic [2:0]      fault_q, fault_d;
  logic [3:0]      q_q, q_d;
  logic [7:0]      phi_q, phi_d;
  logic            rstn_q, rstn_d;
  logic            run_q, run_d;

  logic            ov_hi, oc_hi, shoot, filt_on;
  logic [FW-1:0]   ov_inc, oc_inc;
  logic [2:0]      trip;
  logic            clr_fault;

  always_comb begin
    ov_hi   = i_Vbat > VBAT_MAX;
    oc_hi   = i_Ibat > IBAT_MAX;
    shoot   = (i_MOSFET[0] & i_MOSFET[2])
            | (i_MOSFET[1] & i_MOSFET[3]);
    filt_on = state_q != S_FAULT;
    ov_inc  = (ov_cnt_q == FLT_MAX) ? FLT_MAX
                                    : ov_cnt_q + FW'(1);
    oc_inc  = (oc_cnt_q == FLT_MAX) ? FLT_MAX
                                    : oc_cnt_q + FW'(1);
    trip[0] = filt_on & ov_hi & (ov_inc == FLT_MAX);
    trip[1] = filt_on & oc_hi & (oc_inc == FLT_MAX);
    trip[2] = (state_q == S_RUN) & shoot;

    state_d   = state_q;
    clr_fault = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_BOOT;
      end
      S_BOOT: begin
        if (!i_enable) state_d = S_IDLE;
        else if (timer_q == BOOT_LAST) state_d = S_PRECH;
      end
      S_PRECH: begin
        if (!i_enable) state_d = S_IDLE;
        else if (timer_q == PRECH_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!i_enable) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (i_fault_clear && !i_enable) begin
          state_d   = S_IDLE;
          clr_fault = 1'b1;
        end
      end
      default: state_d = S_FAULT;
    endcase
    if (|trip) state_d = S_FAULT;

    fault_d = clr_fault ? 3'b000 : (fault_q | trip);
    timer_d = (state_d == state_q) ? timer_q + 16'd1
                                   : 16'd0;

    // Counters stay parked at zero while latched in FAULT
    ov_cnt_d = ov_inc;
    oc_cnt_d = oc_inc;
    if (!ov_hi || !filt_on || state_d == S_FAULT)
      ov_cnt_d = '0;
    if (!oc_hi || !filt_on || state_d == S_FAULT)
      oc_cnt_d = '0;

    ramp_d = 16'd0;
    phi_d  = PHI_START;
    if (state_q == S_RUN && state_d == S_RUN) begin
      phi_d = phi_q;
      if (ramp_q == RAMP_LAST) begin
        if (phi_q < i_phi_target)
          phi_d = phi_q + 8'd1;
        else if (phi_q > i_phi_target)
          phi_d = phi_q - 8'd1;
      end else begin
        ramp_d = ramp_q + 16'd1;
      end
    end

    // Pins follow the state being entered, so a trip blanks them at once
    q_d = 4'b0000;
    unique case (state_d)
      S_BOOT:  q_d = 4'b1100;
      S_PRECH: q_d = 4'b1001;
      S_RUN:   q_d = i_MOSFET;
      default: q_d = 4'b0000;
    endcase
    rstn_d = state_d == S_RUN;
    run_d  = state_d == S_RUN;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q  <= S_IDLE;
      timer_q  <= 16'd0;
      ramp_q   <= 16'd0;
      ov_cnt_q <= '0;
      oc_cnt_q <= '0;
      fault_q  <= 3'b000;
      q_q      <= 4'b0000;
      phi_q    <= PHI_START;
      rstn_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ramp_q   <= ramp_d;
      ov_cnt_q <= ov_cnt_d;
      oc_cnt_q <= oc_cnt_d;
      fault_q  <= fault_d;
      q_q      <= q_d;
      phi_q    <= phi_d;
      rstn_q   <= rstn_d;
      run_q    <= run_d;
    end
  end

  assign o_Q          = q_q;
  assign o_phi        = phi_q;
  assign o_ctrl_rst_n = rstn_q;
  assign o_state      = state_q;
  assign o_fault      = fault_q;
  assign o_running    = run_q;

endmodule

// File: tb/tb_hbridge_sequencer.sv
// tb_hbridge_sequencer: vector table, ramp sequence and randomized
// run against a behavioural model of the sequencer.
module tb_hbridge_sequencer;

  localparam int BOOT  = 1000;
  localparam int PRECH = 400;
  localparam int RAMP  = 4;
  localparam int FLT   = 8;
  localparam int VMAX  = 200;
  localparam int IMAX  = 100;
  localparam int NRAND = 40000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] mos = 4'h0;
  logic [7:0] tgt = 8'd0;
  logic [7:0] vb = 8'd0;
  logic [7:0] ib = 8'd0;
  logic [3:0] q;
  logic [7:0] phi;
  logic       crst;
  logic [2:0] st;
  logic [2:0] flt;
  logic       running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hbridge_sequencer #(
    .BOOT_CYCLES (BOOT),
    .PRECH_CYCLES(PRECH),
    .RAMP_CYCLES (RAMP),
    .FLT_FILTER  (FLT)
  ) dut (
    .i_CLK        (clk),
    .i_RST        (rst_n),
    .i_enable     (en),
    .i_fault_clear(clr),
    .i_MOSFET     (mos),
    .i_phi_target (tgt),
    .i_Vbat       (vb),
    .i_Ibat       (ib),
    .o_Q          (q),
    .o_phi        (phi),
    .o_ctrl_rst_n (crst),
    .o_state      (st),
    .o_fault      (flt),
    .o_running    (running)
  );

  typedef struct {
    logic       r;
    logic       e;
    logic       c;
    logic [3:0] m;
    logic [7:0] v;
    logic [7:0] i;
    int         n;
    logic [2:0] s;
    logic [3:0] q;
    logic [2:0] f;
    logic       cr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, e, c,
    input logic [3:0] m,
    input logic [7:0] v, i,
    input int n,
    input logic [2:0] s,
    input logic [3:0] qq,
    input logic [2:0] f,
    input logic cr);
    vec_t x;
    x.r = r; x.e = e; x.c = c; x.m = m;
    x.v = v; x.i = i; x.n = n;
    x.s = s; x.q = qq; x.f = f; x.cr = cr;
    return x;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model: mode number, cycles spent in mode, over-limit run lengths
  int         m_mode, m_el, m_ov, m_oc, m_phi;
  logic [2:0] m_flags;
  logic [3:0] m_q;

  task automatic model_step(input logic r, e, c,
                            input logic [3:0] m,
                            input logic [7:0] t, v, i);
    int nxt;
    logic [2:0] nf;
    if (!r) begin
      m_mode = 0; m_el = 0; m_ov = 0; m_oc = 0;
      m_phi = 0; m_flags = 3'b000; m_q = 4'h0;
      return;
    end
    nf = 3'b000;
    if (m_mode != 4) begin
      m_ov = (int'(v) > VMAX) ? m_ov + 1 : 0;
      m_oc = (int'(i) > IMAX) ? m_oc + 1 : 0;
      nf[0] = m_ov >= FLT;
      nf[1] = m_oc >= FLT;
    end
    nf[2] = (m_mode == 3) &&
            ((m[0] && m[2]) || (m[1] && m[3]));
    nxt = m_mode;
    if (nf != 3'b000) nxt = 4;
    else if (m_mode == 4) begin
      if (c && !e) begin
        nxt = 0;
        m_flags = 3'b000;
      end
    end
    else if (m_mode == 0) begin
      if (e) nxt = 1;
    end
    else if (!e) nxt = 0;
    else if (m_mode == 1 && m_el + 1 == BOOT) nxt = 2;
    else if (m_mode == 2 && m_el + 1 == PRECH) nxt = 3;
    m_flags = m_flags | nf;
    if (nxt == 4) begin
      m_ov = 0;
      m_oc = 0;
    end
    if (nxt != m_mode) begin
      m_el = 0;
      m_phi = 0;
    end else begin
      m_el++;
      if (nxt == 3 && m_el % RAMP == 0) begin
        if (int'(t) > m_phi) m_phi++;
        else if (int'(t) < m_phi) m_phi--;
      end
    end
    if (nxt != 3) m_phi = 0;
    m_mode = nxt;
    m_q = (nxt == 1) ? 4'hC :
          (nxt == 2) ? 4'h9 :
          (nxt == 3) ? m : 4'h0;
  endtask

  initial begin
    int cur_vb_burst, cur_ib_burst;
    logic [3:0] safe [8];
    logic [18:0] act, exp;
    safe = '{4'h0, 4'h1, 4'h2, 4'h3,
             4'h6, 4'h8, 4'h9, 4'hC};

    //         r  e  c  mos   vb    ib    n    st   Q   flt cr
    tbl.push_back(mk(0,0,0,4'h0,8'd0,8'd0,2,    0,4'h0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,8'd0,8'd0,3,    0,4'h0,0,0));
    tbl.push_back(mk(1,1,0,4'h0,8'd0,8'd0,1,    1,4'hC,0,0));
    tbl.push_back(mk(1,1,0,4'h0,8'd0,8'd0,999,  1,4'hC,0,0));
    tbl.push_back(mk(1,1,0,4'h0,8'd0,8'd0,1,    2,4'h9,0,0));
    tbl.push_back(mk(1,1,0,4'h0,8'd0,8'd0,399,  2,4'h9,0,0));
    tbl.push_back(mk(1,1,0,4'h1,8'd0,8'd0,1,    3,4'h1,0,1));
    tbl.push_back(mk(1,1,0,4'h6,8'd0,8'd0,1,    3,4'h6,0,1));
    tbl.push_back(mk(1,0,0,4'h6,8'd0,8'd0,1,    0,4'h0,0,0));
    tbl.push_back(mk(1,1,0,4'h0,8'd0,8'd0,5,    1,4'hC,0,0));
    tbl.push_back(mk(1,0,0,4'h0,8'd0,8'd0,1,    0,4'h0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,8'd0,8'd101,7,  0,4'h0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,8'd0,8'd0,1,    0,4'h0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,8'd200,8'd100,10,0,4'h0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,8'd0,8'd101,7,  0,4'h0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,8'd0,8'd101,1,  4,4'h0,2,0));
    tbl.push_back(mk(1,0,1,4'h0,8'd0,8'd0,1,    0,4'h0,0,0));
    tbl.push_back(mk(1,0,0,4'h0,8'd201,8'd101,8,4,4'h0,3,0));
    tbl.push_back(mk(1,1,1,4'h0,8'd0,8'd0,2,    4,4'h0,3,0));
    tbl.push_back(mk(1,0,1,4'h0,8'd0,8'd0,1,    0,4'h0,0,0));
    tbl.push_back(mk(1,1,0,4'h1,8'd0,8'd0,1401, 3,4'h1,0,1));
    tbl.push_back(mk(1,1,0,4'h5,8'd0,8'd0,1,    4,4'h0,4,0));
    tbl.push_back(mk(1,1,1,4'h0,8'd0,8'd0,3,    4,4'h0,4,0));
    tbl.push_back(mk(1,0,1,4'h0,8'd0,8'd0,1,    0,4'h0,0,0));
    tbl.push_back(mk(1,1,0,4'h9,8'd0,8'd0,1401, 3,4'h9,0,1));
    tbl.push_back(mk(0,1,0,4'h9,8'd0,8'd0,1,    0,4'h0,0,0));

    foreach (tbl[k]) begin
      rst_n = tbl[k].r; en = tbl[k].e; clr = tbl[k].c;
      mos = tbl[k].m; vb = tbl[k].v; ib = tbl[k].i;
      tick(tbl[k].n);
      chk($sformatf("vec%0d.state", k), st, tbl[k].s);
      chk($sformatf("vec%0d.Q", k), q, tbl[k].q);
      chk($sformatf("vec%0d.fault", k), flt, tbl[k].f);
      chk($sformatf("vec%0d.ctrl_rst_n", k), crst, tbl[k].cr);
      chk($sformatf("vec%0d.running", k), running, tbl[k].cr);
      chk($sformatf("vec%0d.phi", k), phi, 0);
    end

    // Ramp up to 5, hold, then retarget down to 3
    rst_n = 1'b1; en = 1'b1; clr = 1'b0;
    mos = 4'h0; vb = 8'd0; ib = 8'd0; tgt = 8'd5;
    tick(BOOT + PRECH + 1);
    chk("ramp.entry_state", st, 3);
    chk("ramp.entry_phi", phi, 0);
    for (int k = 1; k <= 5; k++) begin
      tick(RAMP - 1);
      chk($sformatf("ramp.before%0d", k), phi, k - 1);
      tick(1);
      chk($sformatf("ramp.step%0d", k), phi, k);
    end
    tick(2 * RAMP);
    chk("ramp.hold5", phi, 5);
    tgt = 8'd3;
    tick(RAMP);
    chk("ramp.down4", phi, 4);
    tick(RAMP);
    chk("ramp.down3", phi, 3);
    tick(2 * RAMP);
    chk("ramp.hold3", phi, 3);

    // Randomized run against the model
    cur_vb_burst = 0;
    cur_ib_burst = 0;
    en = 1'b0;
    for (int n = 0; n < NRAND; n++) begin
      rst_n = (n == 0) ? 1'b0 :
              ($urandom_range(0, 9999) != 0);
      if (en) en = ($urandom_range(0, 3999) != 0);
      else    en = ($urandom_range(0, 799) == 0);
      clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0)
        mos = 4'($urandom_range(0, 15));
      else
        mos = safe[$urandom_range(0, 7)];
      if ($urandom_range(0, 49) == 0)
        tgt = 8'($urandom_range(0, 255));
      if (cur_vb_burst == 0 && $urandom_range(0, 7999) == 0)
        cur_vb_burst = $urandom_range(5, 12);
      if (cur_ib_burst == 0 && $urandom_range(0, 7999) == 0)
        cur_ib_burst = $urandom_range(5, 12);
      if (cur_vb_burst > 0) begin
        vb = 8'($urandom_range(201, 255));
        cur_vb_burst--;
      end else begin
        vb = 8'($urandom_range(0, 210));
      end
      if (cur_ib_burst > 0) begin
        ib = 8'($urandom_range(101, 255));
        cur_ib_burst--;
      end else begin
        ib = 8'($urandom_range(0, 105));
      end
      model_step(rst_n, en, clr, mos, tgt, vb, ib);
      tick(1);
      act = {st, q, flt, crst, running, phi};
      exp = {3'(m_mode), m_q, m_flags,
             m_mode == 3, m_mode == 3, 8'(m_phi)};
      chk($sformatf("rand%0d", n), act, exp);
      if (errors > 50) break;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbridge_sequencer.md
# hbridge_sequencer

Start-up, run and protection sequencer for the full-bridge resonant converter. It sits between the hybrid controller / dead-time path and the `Q[3:0]` gate pins. It sequences bootstrap charge, tank pre-charge and run, and ramps the phase reference handed to the hybrid controller. It latches shoot-through, over-voltage and over-current faults from the rectifier sensing path and holds the bridge off until they are cleared.

## Interface
Parameters:
- `BOOT_CYCLES`, 1000: cycles in BOOT (low-side on; 10 us at 100 MHz).
- `PRECH_CYCLES`, 400: cycles in PRECHARGE (sigma=1 forced).
- `RAMP_CYCLES`, 10000: cycles per 1-step move of `o_phi` in RUN.
- `PHI_START`, 8'd0: `o_phi` value outside RUN and at RUN entry.
- `VBAT_MAX`, 8'd200: over-voltage threshold, compared as strict `>` on `i_Vbat`.
- `IBAT_MAX`, 8'd100: over-current threshold, compared as strict `>` on `i_Ibat`.
- `FLT_FILTER`, 8: consecutive over-limit cycles required to trip.

Ports:
- `i_CLK`  in  1  system clock (clk_100M domain).
- `i_RST`  in  1  synchronous reset, active-low.
- `i_enable`  in  1  debounced converter enable (sw[0]).
- `i_fault_clear`  in  1  debounced fault acknowledge.
- `i_MOSFET`  in  4  post-dead-time gate pattern {Q4,Q3,Q2,Q1}.
- `i_phi_target`  in  8  unsigned phase target (saturated PI output or manual value).
- `i_Vbat`  in  8  rectifier voltage, decimal-converted.
- `i_Ibat`  in  8  rectifier current, decimal-converted.
- `o_Q`  out  4  gate drive to pins. Bit0=M1, bit1=M2, bit2=M3, bit3=M4.
- `o_phi`  out  8  ramped phase reference to the hybrid controller.
- `o_ctrl_rst_n`  out  1  active-low reset for the hybrid controller and PI.
- `o_state`  out  3  current state encoding.
- `o_fault`  out  3  latched fault flags {shoot_through, over_current, over_voltage}.
- `o_running`  out  1  high in RUN.

## Operation
State encoding and behaviour:
- IDLE (0):
  - `o_Q`=0000, `o_ctrl_rst_n`=0, `o_phi`=PHI_START.
  - `i_enable`=1 → BOOT; the timer clears.
- BOOT (1):
  - `o_Q`=1100 (M3, M4 low side on).
  - Timer counts up. At `timer==BOOT_CYCLES-1` → PRECHARGE; the timer clears.
- PRECHARGE (2):
  - `o_Q`=1001 (M1, M4; forces sigma=1).
  - At `timer==PRECH_CYCLES-1` → RUN; the timer clears.
- RUN (3):
  - `o_Q` = `i_MOSFET` registered; `o_ctrl_rst_n`=1; `o_running`=1.
  - Every RAMP_CYCLES, `o_phi` moves one step toward `i_phi_target` (+1 or −1). It holds when equal.
- FAULT (4):
  - `o_Q`=0000, `o_ctrl_rst_n`=0, `o_phi`=PHI_START.
  - Leaves to IDLE only when `i_fault_clear`=1 AND `i_enable`=0. That edge also clears `o_fault`.

Enable and fault handling:
- `i_enable`=0 in BOOT, PRECHARGE or RUN → IDLE on the next edge.
- Shoot-through check is active in RUN only: `(i_MOSFET[0]&i_MOSFET[2]) | (i_MOSFET[1]&i_MOSFET[3])`.
  - On detection, `o_Q` is loaded with 0000 on that same edge. The offending pattern never reaches the pins.
  - State → FAULT; `o_fault[2]` sets.
- OV and OC filters are active in all states except FAULT.
  - Each has a saturating counter that increments while over limit and clears when not over limit.
  - The counter reaching FLT_FILTER trips → FAULT and sets the matching flag.
- Priority: `i_RST` > fault trip > `i_enable` low > timer expiry / ramp.
- Simultaneous trips set all matching flags.
- Timer is 16 bit; the ramp counter is separate, 16 bit. Parameters must be < 65536.
- Unused state codes 5–7 → FAULT with no flag set.

## Timing
- All outputs are registered.
- Reset values: `o_Q`=0, `o_phi`=PHI_START, `o_ctrl_rst_n`=0, `o_state`=0, `o_fault`=0, `o_running`=0.
- Enable to first gate: `i_enable` rises at edge k → state=BOOT and `o_Q`=1100 at edge k+1.
- BOOT lasts exactly BOOT_CYCLES cycles. PRECHARGE lasts exactly PRECH_CYCLES cycles.
- RUN pass-through latency: `i_MOSFET` → `o_Q` is 1 cycle.
- `o_ctrl_rst_n` rises on the same edge that enters RUN and falls on the edge that leaves RUN.
- Ramp: the first `o_phi` step occurs RAMP_CYCLES cycles after RUN entry. If `i_phi_target` changes mid-ramp, the direction follows on the next step.
- Trip latency from the first over-limit sample: FLT_FILTER edges to state=FAULT. `o_Q`=0 on the same edge.
- Synchronous reset mid-operation (any state): all outputs return to reset values on the next edge.

## Test plan
- Defaults, enable 0→1 → `o_Q`=1100 for 1000 cycles, then 1001 for 400 cycles, then follows `i_MOSFET` with 1-cycle lag; `o_ctrl_rst_n` rises at cycle 1401.
- RUN with `i_phi_target`=5, RAMP_CYCLES=4 → `o_phi` reads 1,2,3,4,5 at 4-cycle intervals and holds. Then target=3 → `o_phi` steps down to 3.
- RUN, drive `i_MOSFET`=0101 for one cycle → `o_Q`=0000 on that edge, state=4, `o_fault`=100. Clear is refused while `i_enable`=1; with enable=0 → IDLE and `o_fault`=000.
- `i_Ibat`=101 for 7 cycles then 0 → no trip. `i_Ibat`=101 for 8 cycles → FAULT, `o_fault`=010.
- `i_Vbat`=201 and `i_Ibat`=101 together for 8 cycles → `o_fault`=011.
- Drop `i_enable` mid-BOOT → IDLE next edge with `o_Q`=0000. Assert `i_RST`=0 in RUN → all outputs at reset values next edge.
